// File: rtl/bmu_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bmu_scan_ctrl
//  Purpose  : Best-matching-unit scan sequencer for a SOM layer. Issues one
//             request per 4-neuron group to the distance/min-select datapath,
//             folds each returned group minimum into a running global minimum
//             and reports the winning distance and flat neuron index.
//  Ports    : clk_i, rst_i        clock, asynchronous active-high reset
//             start_i             begin scan (IDLE only), num_groups_i sampled
//             busy_o              high while scanning
//             req_valid_o/req_grp_o/req_ready_i   group request handshake
//             in_valid_i/in_dist_i/in_idx_i/in_ready_o  group result handshake
//             done_o              one-cycle completion pulse
//             bmu_dist_o/bmu_idx_o  winning distance / flat zero-based index
//             err_o               sticky illegal local index flag (per scan)
//  Revision : 1.0  initial release
// ============================================================================
module bmu_scan_ctrl #(
  parameter int N   = 16,
  parameter int Q   = 8,
  parameter int G_W = 6
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [G_W-1:0]      num_groups_i,
  output logic                busy_o,
  output logic                req_valid_o,
  output logic [G_W-1:0]      req_grp_o,
  input  logic                req_ready_i,
  input  logic                in_valid_i,
  input  logic signed [N-1:0] in_dist_i,
  input  logic [2:0]          in_idx_i,
  output logic                in_ready_o,
  output logic                done_o,
  output logic signed [N-1:0] bmu_dist_o,
  output logic [G_W+1:0]      bmu_idx_o,
  output logic                err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic signed [N-1:0] DIST_MAX = {1'b0, {(N-1){1'b1}}};

  // The binary point position does not change the ordering of two
  // fixed-point words, so Q only has to describe a sane format.
  if (Q >= N) begin : g_q_range
  end

  state_e                state_q,    state_d;
  logic [G_W-1:0]        num_q,      num_d;
  logic [G_W-1:0]        req_cnt_q,  req_cnt_d;
  logic [G_W-1:0]        resp_cnt_q, resp_cnt_d;
  logic signed [N-1:0]   min_q,      min_d;
  logic [G_W+1:0]        idx_q,      idx_d;
  logic                  err_q,      err_d;
  logic signed [N-1:0]   bmu_dist_q, bmu_dist_d;
  logic [G_W+1:0]        bmu_idx_q,  bmu_idx_d;

  logic                  req_fire;
  logic                  rsp_fire;
  logic                  idx_legal;
  logic [1:0]            local_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      req_cnt_q  <= '0;
      resp_cnt_q <= '0;
      min_q      <= DIST_MAX;
      idx_q      <= '0;
      err_q      <= 1'b0;
      bmu_dist_q <= DIST_MAX;
      bmu_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      req_cnt_q  <= req_cnt_d;
      resp_cnt_q <= resp_cnt_d;
      min_q      <= min_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      bmu_dist_q <= bmu_dist_d;
      bmu_idx_q  <= bmu_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    req_cnt_d  = req_cnt_q;
    resp_cnt_d = resp_cnt_q;
    min_d      = min_q;
    idx_d      = idx_q;
    err_d      = err_q;
    bmu_dist_d = bmu_dist_q;
    bmu_idx_d  = bmu_idx_q;

    busy_o      = (state_q == ST_SCAN);
    in_ready_o  = (state_q == ST_SCAN);
    done_o      = (state_q == ST_DONE);
    req_valid_o = (state_q == ST_SCAN) && (req_cnt_q < num_q);
    req_grp_o   = req_cnt_q;

    req_fire  = req_valid_o && req_ready_i;
    rsp_fire  = in_valid_i && in_ready_o;
    idx_legal = (in_idx_i != 3'd0) && (in_idx_i <= 3'd4);
    // 1..4 -> 0..3; index 4 wraps 00-1 to 11 in two bits.
    local_idx = in_idx_i[1:0] - 2'd1;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          num_d      = num_groups_i;
          req_cnt_d  = '0;
          resp_cnt_d = '0;
          min_d      = DIST_MAX;
          idx_d      = '0;
          err_d      = 1'b0;
          state_d    = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (req_fire) begin
          req_cnt_d = req_cnt_q + 1'b1;
        end
        if (rsp_fire) begin
          resp_cnt_d = resp_cnt_q + 1'b1;
          if (idx_legal) begin
            // Strict compare keeps the earlier (lower-index) winner on ties.
            if (in_dist_i < min_q) begin
              min_d = in_dist_i;
              idx_d = {resp_cnt_q, local_idx};
            end
          end else begin
            err_d = 1'b1;
          end
        end
        // Looking at the post-acceptance count lets the final result be
        // registered on the same edge that enters DONE.
        if (resp_cnt_d == num_q) begin
          state_d    = ST_DONE;
          bmu_dist_d = min_d;
          bmu_idx_d  = idx_d;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bmu_dist_o = bmu_dist_q;
  assign bmu_idx_o  = bmu_idx_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire
